// File: rtl/farm_pkg.sv
// Shared farm actuator definitions: channel indices,
// per-channel FSM state encoding and default tick limits.
package farm_pkg;

  localparam int NCH    = 4;
  localparam int PUMP   = 0;
  localparam int HEATER = 1;
  localparam int COOLER = 2;
  localparam int LIGHT  = 3;

  localparam int DEF_MIN_ON_TICKS   = 4;
  localparam int DEF_MIN_OFF_TICKS  = 8;
  localparam int DEF_PUMP_MAX_TICKS = 30;
  localparam int DEF_CNT_W          = 6;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_ON_MIN,
    CH_ON_HOLD,
    CH_OFF_MIN
  } ch_state_e;

endpackage

// File: rtl/actuator_guard_if.sv
// Guard bus: timebase, requests, override and fault clear
// in; guarded drives, lockout, pump fault and conflict out.
interface actuator_guard_if;
  import farm_pkg::*;

  logic           tick_en;
  logic [NCH-1:0] req;
  logic           override;
  logic           clear_fault;
  logic [NCH-1:0] act;
  logic [NCH-1:0] lockout;
  logic           pump_fault;
  logic           conflict;

  modport master (
    output tick_en, req, override, clear_fault,
    input  act, lockout, pump_fault, conflict
  );

  modport slave (
    input  tick_en, req, override, clear_fault,
    output act, lockout, pump_fault, conflict
  );

endinterface

// File: rtl/actuator_channel.sv
// One actuator: OFF/ON_MIN/ON_HOLD/OFF_MIN FSM + tick counter.
// Ports: clk, rst_n, tick_en, start, req, force_off -> act, lockout.
module actuator_channel
  import farm_pkg::*;
#(
  parameter int MIN_ON_TICKS  = DEF_MIN_ON_TICKS,
  parameter int MIN_OFF_TICKS = DEF_MIN_OFF_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic start,
  input  logic req,
  input  logic force_off,
  output logic act,
  output logic lockout
);

  localparam logic [CNT_W-1:0] ON_LAST =
    CNT_W'(MIN_ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST =
    CNT_W'(MIN_OFF_TICKS - 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             lock_q, lock_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick_en && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      CH_OFF:
        if (start) state_d = CH_ON_MIN;
      CH_ON_MIN:
        if (force_off)
          state_d = CH_OFF_MIN;
        else if (tick_en && cnt_q == ON_LAST)
          state_d = req ? CH_ON_HOLD : CH_OFF_MIN;
      CH_ON_HOLD:
        if (force_off || !req)
          state_d = CH_OFF_MIN;
      CH_OFF_MIN:
        if (tick_en && cnt_q == OFF_LAST)
          state_d = CH_OFF;
      default:
        state_d = CH_OFF;
    endcase
    // Tick on the entry edge itself is not counted.
    if (state_d != state_q)
      cnt_d = '0;
    act_d  = (state_d == CH_ON_MIN) ||
             (state_d == CH_ON_HOLD);
    lock_d = (state_d == CH_OFF_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_OFF;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      lock_q  <= lock_d;
    end
  end

  assign act     = act_q;
  assign lockout = lock_q;

endmodule

// File: rtl/actuator_guard.sv
// Guards four actuators: min on/off, heater/cooler exclusion,
// pump max runtime fault, override. Ports: clk, rst_n, bus.
module actuator_guard
  import farm_pkg::*;
#(
  parameter int MIN_ON_TICKS   = DEF_MIN_ON_TICKS,
  parameter int MIN_OFF_TICKS  = DEF_MIN_OFF_TICKS,
  parameter int PUMP_MAX_TICKS = DEF_PUMP_MAX_TICKS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  actuator_guard_if.slave bus
);

  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(PUMP_MAX_TICKS - 1);

  logic [NCH-1:0]   ch_act, ch_lock;
  logic [NCH-1:0]   start, force_off;
  logic [CNT_W-1:0] run_q, run_d;
  logic             pump_max;
  logic             fault_q, fault_d;
  logic             conf_q, conf_d;
  logic             ovr;

  assign ovr = bus.override;

  always_comb begin
    run_d    = run_q;
    pump_max = 1'b0;
    if (!ch_act[PUMP])
      run_d = '0;
    else if (bus.tick_en) begin
      if (run_q == RUN_LAST)
        pump_max = 1'b1;
      if (run_q != '1)
        run_d = run_q + 1'b1;
    end
  end

  // Setting the fault beats a clear on the same edge.
  always_comb begin
    fault_d = fault_q;
    if (pump_max)
      fault_d = 1'b1;
    else if (bus.clear_fault)
      fault_d = 1'b0;
    conf_d = bus.req[HEATER] & bus.req[COOLER];
  end

  always_comb begin
    start = '0;
    start[PUMP] = bus.req[PUMP] & ~fault_q & ~ovr;
    start[HEATER] = bus.req[HEATER] &
                    ~bus.req[COOLER] &
                    ~ch_act[COOLER] & ~ovr;
    start[COOLER] = bus.req[COOLER] &
                    ~bus.req[HEATER] &
                    ~ch_act[HEATER] & ~ovr;
    start[LIGHT] = bus.req[LIGHT] & ~ovr;
    force_off = {NCH{ovr}};
    force_off[PUMP] = ovr | pump_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= '0;
      fault_q <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      fault_q <= fault_d;
      conf_q  <= conf_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    actuator_channel #(
      .MIN_ON_TICKS (MIN_ON_TICKS),
      .MIN_OFF_TICKS(MIN_OFF_TICKS),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_en  (bus.tick_en),
      .start    (start[i]),
      .req      (bus.req[i]),
      .force_off(force_off[i]),
      .act      (ch_act[i]),
      .lockout  (ch_lock[i])
    );
  end

  assign bus.act        = ch_act;
  assign bus.lockout    = ch_lock;
  assign bus.pump_fault = fault_q;
  assign bus.conflict   = conf_q;

endmodule
